// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words into the instruction ROM and
// holds the CPU in reset until the image is in. Define LOADER_CHECKSUM_EN for a word-sum check.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam logic [32:0] Depth = 33'd1 << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StHdr, StData, StCsum, StRun, StErr} state_e;
`else
    typedef enum logic [2:0] {StHdr, StData, StRun, StErr} state_e;
`endif

    state_e                state_q;
    logic                  hdr_cnt_q;
    logic [7:0]            hdr_lo_q;
    logic [ADDR_WIDTH:0]   n_q;
    logic [1:0]            byte_cnt_q;
    logic [23:0]           asm_q;
    logic [ADDR_WIDTH:0]   word_cnt_q;
    logic                  in_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  cpu_rst_q;
    logic                  load_done_q;
    logic                  load_error_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]           csum_q;
`endif

    logic                  accept;
    logic [31:0]           word_d;
    logic [ADDR_WIDTH:0]   word_nxt_d;
    logic [32:0]           hdr_n_d;
    logic                  last_word_d;

    assign accept      = in_valid && in_ready_q;
    assign word_d      = {in_data, asm_q};
    assign word_nxt_d  = word_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign hdr_n_d     = {17'd0, in_data, hdr_lo_q};
    assign last_word_d = (word_nxt_d == n_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StHdr;
            hdr_cnt_q    <= 1'b0;
            hdr_lo_q     <= 8'd0;
            n_q          <= '0;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 24'd0;
            word_cnt_q   <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_rst_q    <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 32'd0;
`endif
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                StHdr: begin
                    if (accept) begin
                        if (!hdr_cnt_q) begin
                            hdr_lo_q  <= in_data;
                            hdr_cnt_q <= 1'b1;
                        end else begin
                            hdr_cnt_q <= 1'b0;
                            n_q       <= hdr_n_d[ADDR_WIDTH:0];
                            if (hdr_n_d > Depth) begin
                                state_q      <= StErr;
                                in_ready_q   <= 1'b0;
                                load_error_q <= 1'b1;
                            end else if (hdr_n_d == 33'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q    <= StCsum;
`else
                                state_q    <= StRun;
                                in_ready_q <= 1'b0;
`endif
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // Shift in from the top so the first byte lands in bits [7:0].
                        asm_q      <= {in_data, asm_q[23:8]};
                        if (byte_cnt_q == 2'd3) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
                            imem_wdata_q <= word_d;
                            word_cnt_q   <= word_nxt_d;
`ifdef LOADER_CHECKSUM_EN
                            csum_q       <= csum_q + word_d;
                            if (last_word_d) begin
                                state_q <= StCsum;
                            end
`else
                            if (last_word_d) begin
                                state_q    <= StRun;
                                in_ready_q <= 1'b0;
                            end
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StCsum: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        asm_q      <= {in_data, asm_q[23:8]};
                        if (byte_cnt_q == 2'd3) begin
                            in_ready_q <= 1'b0;
                            if (word_d == csum_q) begin
                                state_q <= StRun;
                            end else begin
                                state_q      <= StErr;
                                load_error_q <= 1'b1;
                            end
                        end
                    end
                end
`endif
                StRun: begin
                    // One cycle in RUN lets the final write commit before the CPU fetches.
                    cpu_rst_q   <= 1'b0;
                    load_done_q <= 1'b1;
                end
                StErr: begin
                    cpu_rst_q <= 1'b1;
                end
                default: begin
                    state_q      <= StErr;
                    in_ready_q   <= 1'b0;
                    load_error_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = word_cnt_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Run-time program loader for the pipelined RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them through the instruction-ROM write port starting at word 0. While loading, it holds the CPU in reset, and releases it once the image has been loaded. This replaces bench-side memory preloading, so the same images can be loaded over a host link on hardware.

## Interface
- ADDR_WIDTH, 8: instruction-memory word-address width; capacity DEPTH = 2^ADDR_WIDTH words
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH  word address of the write
- imem_wdata  out  32  assembled instruction word
- cpu_rst  out  1  reset to PipelinedCPU; 1 while loading
- load_done  out  1  image loaded, CPU released
- load_error  out  1  load aborted, CPU held in reset
- words_loaded  out  ADDR_WIDTH+1  count of words written

## Operation
- States: HDR, DATA, CSUM (macro only), RUN, ERR. All outputs are registered.
- A byte is accepted on a rising edge when in_valid && in_ready. in_ready = 1 in HDR, DATA and CSUM; 0 in RUN and ERR.
- Stream format:
  - 2-byte word count N, little-endian.
  - N×4 data bytes, little-endian per word (first byte → bits [7:0]).
  - With the macro: 4 checksum bytes.
- HDR:
  - After 2 bytes, if N > DEPTH → ERR.
  - Else if N == 0 → CSUM (macro) or RUN.
  - Else → DATA.
- DATA:
  - A byte counter (0..3) and a word counter are held.
  - On the 4th byte, the word is presented with imem_we = 1, imem_addr = word counter, and imem_wdata = the assembled word; the word counter then increments.
  - After word N-1 → CSUM (macro) or RUN.
- Word arithmetic: word counter is ADDR_WIDTH+1 bits and never wraps, because N ≤ DEPTH is guaranteed.
- RUN is terminal until rst. Further in_valid is ignored.
- ERR is terminal until rst. cpu_rst stays 1, load_error = 1.
- Gaps: in_valid low between bytes stalls all counters, with no timeout.
- Reset mid-load: returns to HDR with counters cleared and cpu_rst = 1. Words already written remain in memory and are not erased.

## Timing
- Reset values: in_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_rst = 1, load_done = 0, load_error = 0, words_loaded = 0.
- Word write: imem_we is high for exactly the cycle following the edge that accepts the word's 4th byte. words_loaded updates on the same edge.
- Back-to-back bytes give at most one write per 4 cycles. imem_we is never high for two consecutive cycles.
- State transitions into RUN, ERR, DATA or CSUM occur on the edge that accepts the deciding byte. in_ready drops on that same edge when entering RUN or ERR.
- Release sequence:
  - cpu_rst deasserts one cycle after entering RUN, so the final write commits before the first fetch.
  - load_done rises on the same edge as cpu_rst falls.
- load_error rises on the edge entering ERR.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the data bytes, a 4-byte little-endian checksum follows, equal to the sum of all N words mod 2^32.
  - Match → RUN. Mismatch → ERR.
  - N == 0 expects checksum 0.
- Undefined: there is no CSUM state, and the stream ends after the data bytes.

## Test plan
- Basic load (no macro):
  - Stream: 02 00, 13 00 10 00, 93 00 10 00.
  - Required: writes addr0 = 0x00100013 and addr1 = 0x00100093; cpu_rst falls 1 cycle after the last write; load_done = 1; words_loaded = 2.
- Stalled stream:
  - Same image with in_valid low for 3 cycles between every byte.
  - Required: identical writes and values; no extra imem_we pulses.
- Oversize header (ADDR_WIDTH = 8):
  - Header 01 01 (N = 257).
  - Required: ERR after the 2nd byte; load_error = 1; in_ready = 0; cpu_rst stays 1; no writes.
- Mid-load reset:
  - Assert rst after 6 data bytes, then send the full 2-word image.
  - Required: addr0 is rewritten; words_loaded = 2; load_done = 1.
- Checksum (macro defined):
  - 2-word image above with checksum A6 00 20 00 (0x002000A6).
  - Required: RUN.
  - With checksum 00 00 00 00: ERR, cpu_rst held at 1.
- Zero-length image:
  - Header 00 00.
  - Required: no writes; cpu_rst falls 1 cycle after entering RUN; words_loaded = 0.
